mem_access_ctrl: RTL and testbench

Load/store initiator that sits between the core's execute stage and the word-organised data `memory`. It accepts one byte, halfword or word request at a time and drives the memory's word address, write data, byte mask and write enable. It returns aligned, sign- or zero-extended load data. Accesses that straddle a word boundary are split into two consecutive word transactions.

---
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: formats byte/half/word accesses into word transactions; `MISALIGN_EN splits boundary-crossing ones.
// Latency: accept->done 2 cycles aligned, 3 split, 1 on error; o_rdata held until the next o_done.
// Backpressure: single outstanding request; i_req is only taken while o_ready=1, otherwise dropped.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

`ifdef MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t             state, state_nx;
  logic               we_q, uns_q, err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q, lo_q, hi_q, rdata_q;
  logic [7:0]         m8_q;
  logic [63:0]        wd64;
  logic [31:0]        rd32, fmt, resp_rdata;
  logic [ADDR_W-1:0]  word_addr;
  logic               cross_in, err_in;

  // Byte-lane mask over two adjacent words; reserved size yields no lanes.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] sm;
    case (size)
      2'b00:   sm = 8'h01;
      2'b01:   sm = 8'h03;
      2'b10:   sm = 8'h0f;
      default: sm = 8'h00;
    endcase
    return sm << off;
  endfunction

  assign cross_in  = (lane_mask(i_size, i_addr[1:0]) & 8'hf0) != 8'h00;
  assign err_in    = (i_size == 2'b11) || (!SPLIT_EN && cross_in);
  assign m8_q      = lane_mask(size_q, addr_q[1:0]);
  assign wd64      = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign rd32      = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
  assign word_addr = {2'b00, addr_q[ADDR_W-1:2]};

  always_comb begin
    fmt = rd32;
    case (size_q)
      2'b00:   fmt = uns_q ? {24'b0, rd32[7:0]}  : {{24{rd32[7]}},  rd32[7:0]};
      2'b01:   fmt = uns_q ? {16'b0, rd32[15:0]} : {{16{rd32[15]}}, rd32[15:0]};
      default: fmt = rd32;
    endcase
    resp_rdata = (we_q || err_q) ? 32'd0 : fmt;
  end

  always_comb begin
    state_nx    = state;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_rdata     = rdata_q;
    o_mem_addr  = '0;
    o_mem_wdata = 32'd0;
    o_mem_bmask = 4'd0;
    o_mem_wren  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_req) state_nx = err_in ? RESP : ACC0;
      end
      ACC0: begin
        o_mem_addr  = word_addr;
        o_mem_bmask = m8_q[3:0];
        o_mem_wdata = wd64[31:0];
        o_mem_wren  = we_q;
        state_nx    = (SPLIT_EN && (m8_q[7:4] != 4'd0)) ? ACC1 : RESP;
      end
      ACC1: begin
        if (SPLIT_EN) begin
          o_mem_addr  = word_addr + ADDR_W'(1);
          o_mem_bmask = m8_q[7:4];
          o_mem_wdata = wd64[63:32];
          o_mem_wren  = we_q;
        end
        state_nx = RESP;
      end
      RESP: begin
        o_done   = 1'b1;
        o_err    = err_q;
        o_rdata  = resp_rdata;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (i_req) begin
          we_q    <= i_we;
          uns_q   <= i_unsigned;
          err_q   <= err_in;
          addr_q  <= i_addr;
          size_q  <= i_size;
          wdata_q <= i_wdata;
          lo_q    <= 32'd0;
          hi_q    <= 32'd0;
        end
        ACC0:    lo_q    <= i_mem_rdata;
        ACC1:    hi_q    <= i_mem_rdata;
        RESP:    rdata_q <= resp_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory model, scoreboard of expected completions, latency checks.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 32;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_req = 1'b0;
  logic              i_we = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [1:0]        i_size = 2'b00;
  logic              i_unsigned = 1'b0;
  logic [31:0]       i_wdata = 32'd0;
  logic              o_ready, o_done, o_err, o_mem_wren;
  logic [31:0]       o_rdata, o_mem_wdata, i_mem_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [3:0]        o_mem_bmask;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [0:15];
  assign i_mem_rdata = mem[o_mem_addr[3:0]];

  int cyc = 0;
  int wren_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_mem_wren) begin
      wren_cnt <= wren_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (o_mem_bmask[b]) mem[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_reset && o_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_err", o_err, e.err);
        chk("done_rdata", o_rdata, e.rdata);
        chk("done_latency", cyc - e.acc, e.lat);
      end
    end
  end

  int last_acc = 0;

  // Drive one request once the DUT is ready; returns just after the accepting edge.
  task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_rdata, input int lat);
    exp_t e;
    int t = 0;
    @(negedge i_clk);
    while (!o_ready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_ready) chk("ready_timeout", 0, 1);
    i_req = 1'b1; i_we = we; i_addr = addr; i_size = size; i_unsigned = uns; i_wdata = wdata;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    last_acc = cyc;
    e.err = exp_err; e.rdata = exp_rdata; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 10) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, wc;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = 32'h80A17F33;
    mem[5] = 32'hDEADBEEF;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_mem_bmask", o_mem_bmask, 0);
    chk("rst_mem_wren", o_mem_wren, 0);
    @(negedge i_clk);
    i_reset = 1'b1;

    // aligned word load
    req(0, 32'h14, 2'b10, 0, 0, 0, 32'hDEADBEEF, 1);
    chk("lw_mem_addr", o_mem_addr, 5);
    chk("lw_mem_bmask", o_mem_bmask, 4'b1111);
    chk("lw_mem_wren", o_mem_wren, 0);
    wait_done();
    repeat (2) @(negedge i_clk);
    chk("rdata_held", o_rdata, 32'hDEADBEEF);

    // byte / half extension
    req(0, 32'h0A, 2'b00, 0, 0, 0, 32'hFFFFFFA1, 1); wait_done();
    req(0, 32'h0A, 2'b00, 1, 0, 0, 32'h000000A1, 1); wait_done();
    req(0, 32'h09, 2'b00, 0, 0, 0, 32'h0000007F, 1); wait_done();
    req(0, 32'h0A, 2'b01, 0, 0, 0, 32'hFFFF80A1, 1); wait_done();
    req(0, 32'h0A, 2'b01, 1, 0, 0, 32'h000080A1, 1); wait_done();
    req(0, 32'h08, 2'b01, 0, 0, 0, 32'h00007F33, 1); wait_done();

`ifdef MISALIGN_EN
    req(0, 32'h03, 2'b10, 0, 0, 0, 32'h77665544, 2);
    chk("mlw_addr0", o_mem_addr, 0);
    @(posedge i_clk); #1;
    chk("mlw_addr1", o_mem_addr, 1);
    wait_done();
    req(1, 32'h03, 2'b10, 0, 32'hAABBCCDD, 0, 0, 2);
    chk("msw_addr0", o_mem_addr, 0);
    chk("msw_bmask0", o_mem_bmask, 4'b1000);
    chk("msw_wdata0", o_mem_wdata, 32'hDD000000);
    chk("msw_wren0", o_mem_wren, 1);
    @(posedge i_clk); #1;
    chk("msw_addr1", o_mem_addr, 1);
    chk("msw_bmask1", o_mem_bmask, 4'b0111);
    chk("msw_wdata1", o_mem_wdata, 32'h00AABBCC);
    wait_done();
    chk("msw_mem0", mem[0], 32'hDD332211);
    chk("msw_mem1", mem[1], 32'h88AABBCC);
`else
    wc = wren_cnt;
    req(1, 32'h02, 2'b10, 0, 32'hCAFEF00D, 1, 0, 0);
    wait_done();
    chk("msw_no_wren", wren_cnt, wc);
    chk("msw_mem0", mem[0], 32'h44332211);
    chk("msw_mem1", mem[1], 32'h88776655);
    req(0, 32'h03, 2'b01, 0, 0, 1, 0, 0);
    wait_done();
`endif

    // half store into upper lanes
    req(1, 32'h06, 2'b01, 0, 32'h00001234, 0, 0, 1);
    chk("sh_mem_addr", o_mem_addr, 1);
    chk("sh_mem_bmask", o_mem_bmask, 4'b1100);
    chk("sh_mem_wdata", o_mem_wdata, 32'h12340000);
    chk("sh_mem_wren", o_mem_wren, 1);
    wait_done();
`ifdef MISALIGN_EN
    req(0, 32'h04, 2'b10, 0, 0, 0, 32'h1234BBCC, 1);
`else
    req(0, 32'h04, 2'b10, 0, 0, 0, 32'h12346655, 1);
`endif
    wait_done();

    // reserved size
    wc = wren_cnt;
    req(1, 32'h10, 2'b11, 0, 32'hFFFFFFFF, 1, 0, 0);
    chk("rsv_no_access", o_mem_bmask, 0);
    wait_done();
    chk("rsv_no_wren", wren_cnt, wc);
    chk("rsv_mem4", mem[4], 0);

    // reset during an in-flight store
`ifdef MISALIGN_EN
    req(1, 32'h03, 2'b10, 0, 32'h01020304, 0, 0, 2);
    @(posedge i_clk); #1;
`else
    req(1, 32'h20, 2'b10, 0, 32'h5555AAAA, 0, 0, 1);
`endif
    chk("mid_wren_pre", o_mem_wren, 1);
    i_reset = 1'b0;
    #1;
    chk("mid_wren_post", o_mem_wren, 0);
    chk("mid_ready", o_ready, 1);
    chk("mid_done", o_done, 0);
    sb.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
`ifndef MISALIGN_EN
    chk("mid_mem8", mem[8], 0);
`endif

    // back-to-back aligned accesses
    req(0, 32'h14, 2'b10, 0, 0, 0, 32'hDEADBEEF, 1);
    a1 = last_acc;
    req(0, 32'h0A, 2'b01, 0, 0, 0, 32'hFFFF80A1, 1);
    chk("b2b_spacing", last_acc - a1, 3);
    wait_done();

    repeat (2) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
